keypad_entry_ctrl: RTL

//  Sequences the 12-key keypad priority encoder for the ATM front panel.

---
 rtl/keypad_entry_ctrl_pkg.sv | 23 ++
 rtl/keypad_entry_ctrl_debouncer.sv | 56 +++++
 rtl/keypad_entry_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared key codes and FSM state encoding for the ATM keypad entry controller.
// The optional inactivity timeout is enabled with the ENTRY_TIMEOUT_EN macro (see keypad_entry_ctrl).
package keypad_pkg;

   localparam logic [3:0] KEY_CLEAR = 4'd10;
   localparam logic [3:0] KEY_ENTER = 4'd11;
   localparam logic [3:0] KEY_NONE  = 4'd13;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTRY = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Encoder codes 12, 14 and 15 carry no key and are folded onto KEY_NONE.
   function automatic logic [3:0] normalize_code(input logic [3:0] code);
      if (code == 4'd12 || code >= 4'd14) begin
         return KEY_NONE;
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_entry_ctrl_debouncer.sv
// Key code debouncer: accepts a code after DEBOUNCE_CYCLES equal samples and
// flags a press only on a released->key transition of the accepted code.
module key_debouncer
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] key_code,
   output logic [3:0] stable_code,
   output logic       press_pulse,
   output logic [3:0] press_code
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [3:0]    sample;
   logic [3:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    stable_q, stable_d;

   always_comb begin
      sample   = normalize_code(key_code);
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sample != cand_q) begin
         cand_d = sample;
         cnt_d  = CW'(1);
      end else if (cnt_q != CW'(DEBOUNCE_CYCLES)) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CW'(DEBOUNCE_CYCLES)) begin
         stable_d = cand_d;
      end
      // Combinational so the controller acts on the same edge the code is accepted.
      press_pulse = (stable_q == KEY_NONE) && (stable_d != KEY_NONE);
      press_code  = stable_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cand_q   <= KEY_NONE;
         cnt_q    <= '0;
         stable_q <= KEY_NONE;
      end else begin
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_code = stable_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// ATM keypad entry controller: debounced key events build a BCD entry handed off via valid/ack.
// Define ENTRY_TIMEOUT_EN to abandon an entry after TIMEOUT_CYCLES without an accepted key.
module keypad_entry_ctrl
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MAX_DIGITS      = 6,
   parameter int TIMEOUT_CYCLES  = 1000000
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [3:0]                         key_code,
   input  logic                               entry_ack,
   output logic [4*MAX_DIGITS-1:0]            entry_digits,
   output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count,
   output logic                               entry_valid,
   output logic                               key_strobe,
   output logic                               busy,
   output logic                               timeout_abort
);

   localparam int DW = 4 * MAX_DIGITS;
   localparam int CW = $clog2(MAX_DIGITS + 1);

   logic [3:0] unused_stable_code;
   logic       press_pulse;
   logic [3:0] press_code;

   key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clock       (clock),
      .reset       (reset),
      .key_code    (key_code),
      .stable_code (unused_stable_code),
      .press_pulse (press_pulse),
      .press_code  (press_code)
   );

   state_t        state_q, state_d;
   logic [DW-1:0] digits_q, digits_d;
   logic [CW-1:0] count_q, count_d;
   logic          strobe_q, strobe_d;
   logic          is_digit;

`ifdef ENTRY_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          abort_q, abort_d;
`endif

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      count_d  = count_q;
      strobe_d = 1'b0;
      is_digit = (press_code <= 4'd9);
`ifdef ENTRY_TIMEOUT_EN
      abort_d  = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (press_pulse && is_digit) begin
               digits_d      = '0;
               digits_d[3:0] = press_code;
               count_d       = CW'(1);
               state_d       = ST_ENTRY;
               strobe_d      = 1'b1;
            end
         end
         ST_ENTRY: begin
            if (press_pulse && is_digit) begin
               // A full buffer silently drops further digits.
               if (count_q < CW'(MAX_DIGITS)) begin
                  digits_d = {digits_q[DW-5:0], press_code};
                  count_d  = count_q + 1'b1;
                  strobe_d = 1'b1;
               end
            end else if (press_pulse && press_code == KEY_CLEAR) begin
               digits_d = '0;
               count_d  = '0;
               state_d  = ST_IDLE;
               strobe_d = 1'b1;
            end else if (press_pulse && press_code == KEY_ENTER) begin
               state_d  = ST_DONE;
               strobe_d = 1'b1;
`ifdef ENTRY_TIMEOUT_EN
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               digits_d = '0;
               count_d  = '0;
               state_d  = ST_IDLE;
               abort_d  = 1'b1;
`endif
            end
         end
         ST_DONE: begin
            if (entry_ack) begin
               digits_d = '0;
               count_d  = '0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
`ifdef ENTRY_TIMEOUT_EN
      // Idle time is measured only inside ENTRY and restarts on every accepted key.
      if (state_q != ST_ENTRY || strobe_d || abort_d) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         digits_q <= '0;
         count_q  <= '0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         count_q  <= count_d;
         strobe_q <= strobe_d;
      end
   end

`ifdef ENTRY_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         abort_q <= abort_d;
      end
   end

   assign timeout_abort = abort_q;
`else
   assign timeout_abort = 1'b0;
`endif

   assign entry_digits = digits_q;
   assign digit_count  = count_q;
   assign entry_valid  = (state_q == ST_DONE);
   assign busy         = (state_q != ST_IDLE);
   assign key_strobe   = strobe_q;

endmodule
